// File: rtl/move_entry.sv
// move_entry: synchronises and debounces the 8 player switch pins and hands each new stable
// setting to the solitaire core as one valid/ready move command. Optional macro: MOVE_FILTER_EN.
module move_entry #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] raw_in,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [2:0] move_x,
    output logic [2:0] move_y,
    output logic [1:0] move_dir,
    output logic       move_reject,
    output logic       busy
);
    localparam int               CNT_W    = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ISSUE  = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [7:0]                  samp;
    logic [7:0]                  cand_q, cand_d;
    logic [7:0]                  last_q, last_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        move_valid_q, move_valid_d;
    logic [2:0]                  move_x_q, move_x_d;
    logic [2:0]                  move_y_q, move_y_d;
    logic [1:0]                  move_dir_q, move_dir_d;
    logic                        move_reject_q, move_reject_d;
    logic                        busy_q, busy_d;
    logic                        on_board;

`ifdef MOVE_FILTER_EN
    // A hole exists on the cross board unless both coordinates lie in the cut-away corners.
    function automatic logic cross_board_hole(input logic [7:0] setting);
        logic [2:0] x;
        logic [2:0] y;
        logic       x_arm;
        logic       y_arm;
        x     = setting[2:0];
        y     = setting[5:3];
        x_arm = (x == 3'd0) || (x == 3'd1) || (x == 3'd5) || (x == 3'd6);
        y_arm = (y == 3'd0) || (y == 3'd1) || (y == 3'd5) || (y == 3'd6);
        return !((x == 3'd7) || (y == 3'd7) || (x_arm && y_arm));
    endfunction

    assign on_board = cross_board_hole(cand_q);
`else
    assign on_board = 1'b1;
`endif

    assign samp   = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};

    // Next-state and next-output logic for the settle/issue controller.
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        move_valid_d  = move_valid_q;
        move_x_d      = move_x_q;
        move_y_d      = move_y_q;
        move_dir_d    = move_dir_q;
        move_reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (samp != last_q) begin
                    cand_d  = samp;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (samp != cand_q) begin
                    cand_d = samp;
                    cnt_d  = '0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = '0;
                    // A bounce that settles back onto the last accepted setting is not a new move.
                    if (cand_q == last_q) begin
                        state_d = IDLE;
                    end else if (!on_board) begin
                        last_d        = cand_q;
                        move_reject_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        move_x_d     = cand_q[2:0];
                        move_y_d     = cand_q[5:3];
                        move_dir_d   = cand_q[7:6];
                        move_valid_d = 1'b1;
                        state_d      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (move_ready) begin
                    last_d       = cand_q;
                    move_valid_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    move_valid_d = 1'b1;
                end
            end
            default: begin
                move_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, synchroniser and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            cand_q        <= 8'd0;
            last_q        <= 8'd0;
            cnt_q         <= '0;
            move_valid_q  <= 1'b0;
            move_x_q      <= 3'd0;
            move_y_q      <= 3'd0;
            move_dir_q    <= 2'd0;
            move_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            cand_q        <= cand_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            move_valid_q  <= move_valid_d;
            move_x_q      <= move_x_d;
            move_y_q      <= move_y_d;
            move_dir_q    <= move_dir_d;
            move_reject_q <= move_reject_d;
            busy_q        <= busy_d;
        end
    end

    assign move_valid  = move_valid_q;
    assign move_x      = move_x_q;
    assign move_y      = move_y_q;
    assign move_dir    = move_dir_q;
    assign move_reject = move_reject_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_move_entry.sv
// Bench for move_entry: directed vector table, hand-written handshake/reset sequences and a
// random run against a run-length based reference model. Honors MOVE_FILTER_EN if defined.
module tb_move_entry;
    localparam int SS = 2;
    localparam int S  = 16;
`ifdef MOVE_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] raw_in;
    logic       move_ready;
    logic       move_valid;
    logic [2:0] move_x;
    logic [2:0] move_y;
    logic [1:0] move_dir;
    logic       move_reject;
    logic       busy;

    int total;
    int bad;

    move_entry #(.SYNC_STAGES(SS), .SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .move_x     (move_x),
        .move_y     (move_y),
        .move_dir   (move_dir),
        .move_reject(move_reject),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] raw;
        bit         exp_issue;
        bit         exp_rej;
        logic [2:0] ex;
        logic [2:0] ey;
        logic [1:0] ed;
    } vec_t;

    vec_t vecs[8];

    // Reference model state: time-stamped runs of the synchronised value.
    logic [7:0] m_pipe[SS];
    logic [7:0] m_last, m_prev, m_pend;
    int         m_cyc, m_run, m_set;
    bit         m_settling, m_issuing, m_rej;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input logic [7:0] s);
        int  x;
        int  y;
        bit  geo;
        x   = int'(s[2:0]);
        y   = int'(s[5:3]);
        geo = !((x == 7) || (y == 7) || ((x inside {0, 1, 5, 6}) && (y inside {0, 1, 5, 6})));
        return !FILTER_ON || geo;
    endfunction

    task automatic model_init();
        for (int i = 0; i < SS; i++) m_pipe[i] = 8'd0;
        m_last = 8'd0; m_prev = 8'd0; m_pend = 8'd0;
        m_cyc = 0; m_run = 0; m_set = 0;
        m_settling = 1'b0; m_issuing = 1'b0; m_rej = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present before that edge.
    task automatic model_step(input logic [7:0] raw, input bit rdy);
        logic [7:0] samp;
        int         ws;
        samp = m_pipe[SS-1];
        if (samp != m_prev) m_run = m_cyc;
        m_prev = samp;
        m_rej  = 1'b0;
        if (m_issuing) begin
            if (rdy) begin
                m_last    = m_pend;
                m_issuing = 1'b0;
            end
        end else if (!m_settling) begin
            if (samp != m_last) begin
                m_settling = 1'b1;
                m_set      = m_cyc;
            end
        end else begin
            ws = (m_run > m_set) ? m_run : m_set;
            if (m_cyc - ws == S) begin
                m_settling = 1'b0;
                if (samp == m_last) begin
                    m_rej = 1'b0;
                end else if (!legal(samp)) begin
                    m_last = samp;
                    m_rej  = 1'b1;
                end else begin
                    m_issuing = 1'b1;
                    m_pend    = samp;
                end
            end
        end
        for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = raw;
        m_cyc++;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            step();
            if (move_valid) ok = 1'b1;
        end
    endtask

    initial begin
        bit         ok;
        bit         early;
        bit         flag;
        int         ncmd;
        int         hold;
        logic [7:0] r;
        logic [7:0] got;
        bit         rdy;

        total = 0; bad = 0;
        rst_n = 1'b0; raw_in = 8'd0; move_ready = 1'b0;

        vecs[0] = '{8'h5B, 1'b1, 1'b0, 3'd3, 3'd3, 2'd1};
        vecs[1] = '{8'h5B, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0};
        vecs[2] = '{8'hB4, 1'b1, 1'b0, 3'd4, 3'd6, 2'd2};
        vecs[3] = '{8'h40, !FILTER_ON, FILTER_ON, 3'd0, 3'd0, 2'd1};
        vecs[4] = '{8'h03, 1'b1, 1'b0, 3'd3, 3'd0, 2'd0};
        vecs[5] = '{8'hEF, !FILTER_ON, FILTER_ON, 3'd7, 3'd5, 2'd3};
        vecs[6] = '{8'h00, !FILTER_ON, FILTER_ON, 3'd0, 3'd0, 2'd0};
        vecs[7] = '{8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0};

        // Reset state, then a long idle with all-zero pins.
        for (int i = 0; i < 3; i++) step();
        check("reset_state", {move_valid, move_x, move_y, move_dir, move_reject, busy}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            step();
            check("idle_zero", {move_valid, move_x, move_y, move_dir, move_reject, busy}, 32'd0);
        end

        // Vector table: exact latency S+SS+1 edges after the pins change.
        move_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            raw_in = vecs[v].raw;
            early  = 1'b0;
            for (int j = 1; j <= S + SS; j++) begin
                step();
                if (move_valid || move_reject) early = 1'b1;
            end
            check("tbl_early", early, 1'b0);
            step();
            check("tbl_valid", move_valid, vecs[v].exp_issue);
            check("tbl_reject", move_reject, vecs[v].exp_rej);
            if (vecs[v].exp_issue) begin
                check("tbl_x", move_x, vecs[v].ex);
                check("tbl_y", move_y, vecs[v].ey);
                check("tbl_dir", move_dir, vecs[v].ed);
            end
            step();
            check("tbl_pulse_end", {move_valid, move_reject}, 2'b00);
            for (int j = 0; j < 5; j++) step();
        end

        // Bounce on bit0 every 5 cycles, then hold x=2,y=3.
        flag = 1'b0;
        for (int i = 0; i < 100; i++) begin
            raw_in = 8'h1A ^ (((i / 5) % 2) != 0 ? 8'h01 : 8'h00);
            step();
            if (i >= 5 && (!busy || move_valid)) flag = 1'b1;
        end
        check("bounce_busy", flag, 1'b0);
        raw_in = 8'h1A;
        ncmd = 0; got = 8'd0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (move_valid) begin
                ncmd++;
                got = {move_dir, move_y, move_x};
            end
        end
        check("bounce_count", ncmd, 1);
        check("bounce_data", got, 8'h1A);

        // Backpressure: data frozen while ready is low, change to x=4 follows after accept.
        move_ready = 1'b0;
        raw_in     = 8'h93;
        wait_valid(ok);
        check("bp_first_valid", ok, 1'b1);
        raw_in = 8'h94;
        flag   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!move_valid || {move_dir, move_y, move_x} != 8'h93) flag = 1'b1;
        end
        check("bp_frozen", flag, 1'b0);
        move_ready = 1'b1;
        step();
        check("bp_accept_drop", move_valid, 1'b0);
        wait_valid(ok);
        check("bp_second_valid", ok, 1'b1);
        check("bp_second_data", {move_dir, move_y, move_x}, 8'h94);
        step();
        check("bp_second_drop", move_valid, 1'b0);

        // Same setting held: no repeat.
        flag = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (move_valid) flag = 1'b1;
        end
        check("repeat_none", flag, 1'b0);
        check("repeat_busy", busy, 1'b0);

        // Reset during ISSUE drops valid next cycle; nothing replays.
        move_ready = 1'b0;
        raw_in     = 8'hE3;
        wait_valid(ok);
        check("rst_issue_valid", ok, 1'b1);
        rst_n  = 1'b0;
        raw_in = 8'h00;
        step();
        check("rst_issue_drop", {move_valid, move_x, move_y, move_dir, move_reject, busy}, 32'd0);
        rst_n = 1'b1;
        move_ready = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (move_valid) flag = 1'b1;
        end
        check("rst_no_replay", flag, 1'b0);

        // Random run against the reference model.
        rst_n = 1'b0; raw_in = 8'd0; move_ready = 1'b0;
        step();
        rst_n = 1'b1;
        model_init();
        r = 8'd0; hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0:       r = 8'($urandom_range(0, 255));
                    1:       r = r ^ (8'd1 << $urandom_range(0, 7));
                    2:       r = r;
                    default: r = 8'($urandom);
                endcase
                hold = ($urandom_range(0, 2) == 0) ? $urandom_range(18, 40) : $urandom_range(1, 6);
            end
            hold--;
            rdy        = ($urandom_range(0, 3) != 0);
            raw_in     = r;
            move_ready = rdy;
            step();
            model_step(r, rdy);
            check("rnd_valid", move_valid, m_issuing);
            check("rnd_busy", busy, m_issuing || m_settling);
            check("rnd_reject", move_reject, m_rej);
            if (m_issuing) check("rnd_data", {move_dir, move_y, move_x}, m_pend);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
